// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register-write controller.
package spi_reg_pkg;
  localparam int FRAME_W = 16;

  localparam logic [6:0] ADDR_EN_OUT_7_0  = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_15_8 = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_7_0  = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_15_8 = 7'h03;
  localparam logic [6:0] ADDR_PWM_DUTY    = 7'h04;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} ctrl_state_t;

  typedef struct packed {
    logic       write;
    logic [6:0] addr;
    logic [7:0] data;
  } spi_req_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction
endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK half-period generator; idles low and restarts from a full low half whenever en drops.
module spi_sclk_gen #(
  parameter int CLK_DIV = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sclk,
  output logic rise,
  output logic fall
);
  localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [HW-1:0] hp_cnt;
  logic          wrap;

  assign wrap = en && (hp_cnt == HW'(CLK_DIV - 1));
  assign rise = wrap && !sclk;
  assign fall = wrap && sclk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hp_cnt <= '0;
      sclk   <= 1'b0;
    end else if (!en) begin
      hp_cnt <= '0;
      sclk   <= 1'b0;
    end else if (wrap) begin
      hp_cnt <= '0;
      sclk   <= ~sclk;
    end else begin
      hp_cnt <= hp_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/spi_reg_controller.sv
// SPI mode-0 initiator: one parallel register request becomes one 16-bit MSB-first frame.
module spi_reg_controller
  import spi_reg_pkg::*;
#(
  parameter int CLK_DIV  = 8,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int IDLE_GAP = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_data,
  output logic       busy,
  output logic       done,
  output logic       spi_sclk,
  output logic       spi_copi,
  output logic       spi_cs
);
  localparam int CNT_W = $clog2(max3(CS_SETUP, CS_HOLD, IDLE_GAP) + 1);

  ctrl_state_t        state, nstate;
  spi_req_t           req;
  logic [FRAME_W-1:0] sr;
  logic [4:0]         bit_cnt;
  logic [CNT_W-1:0]   cyc_cnt;
  logic               accept, sclk_rise, sclk_fall, last_fall, phase_end;
  logic               cs_d, busy_d, done_d, ready_d;

  assign req       = {req_write, req_addr, req_data};
  assign accept    = req_valid && req_ready;
  // bit_cnt counts rising edges, so the fall after the 16th rise closes the frame
  assign last_fall = sclk_fall && (bit_cnt == 5'd16);

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
    .clk  (clk),
    .rst  (rst),
    .en   (state == SHIFT),
    .sclk (spi_sclk),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  always_comb begin
    case (state)
      SETUP:   phase_end = (cyc_cnt == CNT_W'(CS_SETUP - 1));
      HOLD:    phase_end = (cyc_cnt == CNT_W'(CS_HOLD - 1));
      GAP:     phase_end = (cyc_cnt == CNT_W'(IDLE_GAP - 1));
      default: phase_end = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      spi_cs    <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      req_ready <= 1'b1;
    end else begin
      state     <= nstate;
      spi_cs    <= cs_d;
      busy      <= busy_d;
      done      <= done_d;
      req_ready <= ready_d;
    end
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (accept)    nstate = SETUP;
      SETUP:   if (phase_end) nstate = SHIFT;
      SHIFT:   if (last_fall) nstate = HOLD;
      HOLD:    if (phase_end) nstate = GAP;
      GAP:     if (phase_end) nstate = IDLE;
      default:                nstate = IDLE;
    endcase
  end

  // Pin values are decoded from the next state so every pin leaves a flop.
  always_comb begin
    cs_d    = !(nstate == SETUP || nstate == SHIFT || nstate == HOLD);
    busy_d  = (nstate != IDLE);
    ready_d = (nstate == IDLE);
    done_d  = (state == HOLD) && (nstate == GAP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr       <= '0;
      bit_cnt  <= '0;
      cyc_cnt  <= '0;
      spi_copi <= 1'b0;
    end else begin
      cyc_cnt <= (nstate != state) ? '0 : cyc_cnt + 1'b1;
      if (accept) begin
        sr       <= req;
        spi_copi <= req.write;
        bit_cnt  <= '0;
      end else if (state == SHIFT) begin
        if (sclk_rise) bit_cnt <= bit_cnt + 1'b1;
        if (sclk_fall) begin
          sr       <= {sr[FRAME_W-2:0], 1'b0};
          spi_copi <= last_fall ? 1'b0 : sr[FRAME_W-2];
        end
      end
    end
  end
endmodule

// File: tb/tb_spi_reg_controller.sv
// Bench for spi_reg_controller: timing model per cycle plus a behavioural SPI peripheral.
module tb_spi_reg_controller;
  import spi_reg_pkg::*;

  localparam int DIV  = 8;
  localparam int SET  = 2;
  localparam int HLD  = 2;
  localparam int GAPC = 4;
  localparam int LOW  = SET + 32 * DIV + HLD;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic req_valid = 1'b0, req_write = 1'b0;
  logic [6:0] req_addr = '0;
  logic [7:0] req_data = '0;
  logic req_ready, busy, done, spi_sclk, spi_copi, spi_cs;

  int tests = 0, fails = 0;

  spi_reg_controller #(.CLK_DIV(DIV), .CS_SETUP(SET), .CS_HOLD(HLD), .IDLE_GAP(GAPC)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_data(req_data),
    .busy(busy), .done(done), .spi_sclk(spi_sclk), .spi_copi(spi_copi), .spi_cs(spi_cs)
  );

  always #5 clk = ~clk;

  // Model: k = cycles since the accept edge while a transaction is in flight
  bit          m_active = 1'b0;
  int          m_k = 0;
  int          m_acc = 0;
  logic [15:0] m_frame = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active <= 1'b0;
      m_k      <= 0;
    end else if (!m_active) begin
      if (req_valid) begin
        m_active <= 1'b1;
        m_k      <= 1;
        m_frame  <= {req_write, req_addr, req_data};
        m_acc    <= m_acc + 1;
      end
    end else if (m_k == LOW + GAPC) begin
      m_active <= 1'b0;
    end else begin
      m_k <= m_k + 1;
    end
  end

  function automatic logic [5:0] model_out(input bit act, input int k, input logic [15:0] f);
    logic cs, sclk, copi, bsy, dn, rdy;
    int s;
    cs = 1; sclk = 0; copi = 0; bsy = 0; dn = 0; rdy = 1;
    if (act) begin
      bsy = 1; rdy = 0;
      cs  = (k > LOW);
      dn  = (k == LOW + 1);
      if (k <= SET) copi = f[15];
      else if (k <= SET + 32 * DIV) begin
        s    = k - 1 - SET;
        sclk = (s % (2 * DIV)) >= DIV;
        copi = f[15 - s / (2 * DIV)];
      end
    end
    return {cs, sclk, copi, bsy, dn, rdy};
  endfunction

  // Behavioural peripheral: samples COPI on SCLK rise, commits 16-bit write frames on CS rise
  logic [7:0]  pregs [128];
  logic [15:0] psh = '0, last_frame = '0;
  int nb = 0, frames = 0, done_cnt = 0, hi_run = 0, lo_run = 0, last_cs_high = 0, last_cs_low = 0;
  logic prev_cs = 1'b1, prev_sclk = 1'b0;

  initial for (int i = 0; i < 128; i++) pregs[i] = '0;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (!spi_cs && prev_cs) begin last_cs_high = hi_run; hi_run = 0; nb = 0; end
    if (spi_cs && !prev_cs) begin
      last_cs_low = lo_run; lo_run = 0;
      if (nb == 16) begin
        last_frame = psh; frames++;
        if (psh[15]) pregs[psh[14:8]] = psh[7:0];
      end
    end
    if (!spi_cs && spi_sclk && !prev_sclk) begin psh = {psh[14:0], spi_copi}; nb++; end
    if (spi_cs) hi_run++; else lo_run++;
    prev_cs = spi_cs; prev_sclk = spi_sclk;
  end

  logic [7:0] exp_regs [128];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_loop();
    logic [5:0] e;
    forever begin
      @(negedge clk);
      e = model_out(m_active, m_k, m_frame);
      check("cyc_cs",    int'(spi_cs),    int'(e[5]));
      check("cyc_sclk",  int'(spi_sclk),  int'(e[4]));
      check("cyc_copi",  int'(spi_copi),  int'(e[3]));
      check("cyc_busy",  int'(busy),      int'(e[2]));
      check("cyc_done",  int'(done),      int'(e[1]));
      check("cyc_ready", int'(req_ready), int'(e[0]));
    end
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 400 && m_active; i++) @(negedge clk);
    check(name, int'(m_active), 0);
  endtask

  task automatic wait_accept(input int acc0, input int budget, input string name);
    for (int i = 0; i < budget && m_acc == acc0; i++) @(negedge clk);
    check(name, m_acc - acc0, 1);
  endtask

  task automatic do_frame(input logic w, input logic [6:0] a, input logic [7:0] d, input int gap);
    int acc0;
    @(negedge clk);
    acc0 = m_acc;
    req_valid = 1'b1; req_write = w; req_addr = a; req_data = d;
    @(negedge clk);
    wait_accept(acc0, 20, "accept");
    req_valid = 1'b0;
    req_write = 1'($urandom); req_addr = 7'($urandom); req_data = 8'($urandom);
    wait_idle("frame_end");
    @(negedge clk);
    check("frame_bits", int'(last_frame), int'({w, a, d}));
    if (w) exp_regs[a] = d;
    check("periph_reg", int'(pregs[a]), int'(exp_regs[a]));
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    int acc0, fr0, dc0;
    for (int i = 0; i < 128; i++) exp_regs[i] = '0;
    fork compare_loop(); join_none

    // 1: reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_cs",    int'(spi_cs), 1);
    check("rst_sclk",  int'(spi_sclk), 0);
    check("rst_copi",  int'(spi_copi), 0);
    check("rst_ready", int'(req_ready), 1);
    check("rst_busy",  int'(busy), 0);
    check("rst_done",  int'(done), 0);

    // 2: single write to the duty-cycle register
    dc0 = done_cnt;
    do_frame(1'b1, ADDR_PWM_DUTY, 8'h80, 2);
    check("t2_frame",  int'(last_frame), 32'h8480);
    check("t2_cs_low", last_cs_low, 260);
    check("t2_done",   done_cnt - dc0, 1);
    check("t2_duty",   int'(pregs[ADDR_PWM_DUTY]), 32'h80);

    // 3: back-to-back writes with req_valid held high
    @(negedge clk);
    acc0 = m_acc;
    req_valid = 1'b1; req_write = 1'b1; req_addr = ADDR_EN_OUT_7_0; req_data = 8'hFF;
    @(negedge clk);
    wait_accept(acc0, 20, "t3_accept1");
    req_addr = ADDR_EN_PWM_7_0; req_data = 8'h0F;
    wait_accept(acc0 + 1, 400, "t3_accept2");
    req_valid = 1'b0;
    wait_idle("t3_end");
    @(negedge clk);
    exp_regs[0] = 8'hFF; exp_regs[2] = 8'h0F;
    check("t3_gap",     last_cs_high, GAPC + 1);
    check("t3_en_out",  int'(pregs[ADDR_EN_OUT_7_0]), 32'hFF);
    check("t3_en_pwm",  int'(pregs[ADDR_EN_PWM_7_0]), 32'h0F);

    // 4: read frame is clocked out but changes nothing
    fr0 = frames;
    do_frame(1'b0, ADDR_EN_OUT_15_8, 8'hAA, 1);
    check("t4_frame", int'(last_frame), 32'h01AA);
    check("t4_count", frames - fr0, 1);
    check("t4_reg",   int'(pregs[ADDR_EN_OUT_15_8]), 0);

    // 5: reset during bit 7
    fr0 = frames;
    @(negedge clk);
    acc0 = m_acc;
    req_valid = 1'b1; req_write = 1'b1; req_addr = ADDR_EN_PWM_15_8; req_data = 8'h11;
    @(negedge clk);
    wait_accept(acc0, 20, "t5_accept");
    req_valid = 1'b0;
    for (int i = 0; i < 200 && !(m_active && m_k == 119); i++) @(negedge clk);
    check("t5_reach_bit7", m_k, 119);
    #2 rst = 1'b1;
    #1;
    check("t5_cs_async",   int'(spi_cs), 1);
    check("t5_sclk_async", int'(spi_sclk), 0);
    check("t5_copi_async", int'(spi_copi), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t5_ready",   int'(req_ready), 1);
    check("t5_dropped", frames - fr0, 0);
    check("t5_reg",     int'(pregs[ADDR_EN_PWM_15_8]), 0);
    do_frame(1'b1, ADDR_EN_PWM_15_8, 8'h5A, 0);
    check("t5_after",   int'(pregs[ADDR_EN_PWM_15_8]), 32'h5A);

    // 6: input churn mid-frame
    fr0 = frames;
    @(negedge clk);
    acc0 = m_acc;
    req_valid = 1'b1; req_write = 1'b1; req_addr = ADDR_EN_PWM_7_0; req_data = 8'h33;
    @(negedge clk);
    wait_accept(acc0, 20, "t6_accept");
    for (int i = 0; i < 40; i++) begin
      req_valid = 1'($urandom); req_data = 8'($urandom);
      req_addr = 7'($urandom); req_write = 1'($urandom);
      @(negedge clk);
    end
    req_valid = 1'b0;
    wait_idle("t6_end");
    @(negedge clk);
    exp_regs[2] = 8'h33;
    check("t6_frame",  int'(last_frame), 32'h8233);
    check("t6_count",  frames - fr0, 1);
    check("t6_accept", m_acc - acc0, 1);

    // random frames
    for (int n = 0; n < 12; n++)
      do_frame(1'($urandom), 7'($urandom_range(0, 127)), 8'($urandom), int'($urandom_range(0, 3)));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
